time_display_scan: RTL and testbench
====================================

Name: time_display_scan

Overview:
- Display-side consumer of the clock/stopwatch time bus (centsegundos, segundos, minutos, hora, nrc).
- Converts each binary field to two BCD digits, encodes them as seven-segment patterns, and time-multiplexes 8 common-anode digits as HH.MM.SS.cc.
- Captures a coherent snapshot of the time bus once per scan frame, so a carry mid-frame cannot tear the display.

Parameters:
- SCAN_DIV, 1000: clk cycles each digit stays lit; legal range >= 1.
- BLANK_CYCLES, 2: all-off cycles between digits, for anti-ghosting; 0 means the gap is skipped.

Ports:
- clk  input  1  system clock, rising edge.
- res  input  1  asynchronous reset, active-high.
- centsegundos  input  7  hundredths of a second, binary; 0..99 valid.
- segundos  input  6  seconds, binary; 0..59 valid.
- minutos  input  6  minutes, binary; 0..59 valid.
- hora  input  5  hours, binary; 0..23 valid.
- nrc  input  1  1 = clock mode, 0 = stopwatch mode.
- blank_lead  input  1  1 = suppress the hour tens digit when hora < 10.
- an  output  8  digit enables, active-low; an[7] = hour tens … an[0] = cents units.
- seg  output  7  segments, active-low; bit order {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low.
- frame  output  1  one-cycle pulse at the start of each frame (snapshot cycle).

Behaviour:
- All outputs are registered.
- While res=1, outputs are held at: an=8'hFF, seg=7'h7F, dp=1, frame=0. Internal state: state=SNAP, digit index=7, cycle counter=0, snapshot=0.
- FSM states: SNAP, SHOW, GAP.
- SNAP (1 cycle):
  - Snapshot registers load all time-bus inputs, nrc and blank_lead.
  - frame=1, an=8'hFF.
  - Next state: SHOW, with digit index=7.
- SHOW (exactly SCAN_DIV cycles):
  - an[idx]=0, all other an bits 1.
  - seg and dp are driven from the snapshot only.
  - On completion: go to GAP if BLANK_CYCLES>0; otherwise go straight to the next digit.
- GAP (exactly BLANK_CYCLES cycles):
  - an=8'hFF, seg=7'h7F, dp=1.
  - Next: if idx>0, decrement idx and return to SHOW; if idx=0, go to SNAP.
- Frame period = 1 + 8*(SCAN_DIV+BLANK_CYCLES) cycles. frame is 0 in every cycle except SNAP.
- The first SNAP occurs in the first clk cycle after res deasserts, so frame pulses there.
- Field-to-digit mapping:
  - idx 7/6 = hora tens/units.
  - idx 5/4 = minutos tens/units.
  - idx 3/2 = segundos tens/units.
  - idx 1/0 = centsegundos tens/units.
  - tens = v/10, units = v%10, computed on the snapshot value.
- Segment codes:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - dash=3F, blank=7F (hex, 7 bits).
- Out-of-range field (cents>99, sec>59, min>59, hour>23): both digits of that field show dash; other fields are unaffected.
- Leading blank: if the snapshot has blank_lead=1 and hora<10, digit 7 shows seg=7F and its anode is still asserted.
  - This does not apply when hora is out of range; dash takes priority.
- Decimal points:
  - dp=0 on idx 6, 4 and 2 (field separators).
  - dp=0 on idx 0 only if snapshot nrc=1 (clock-mode indicator).
  - dp=1 on all other digits.
- Input changes after SNAP have no visible effect until the next SNAP.
- res asserted mid-frame (any state) forces reset values within the same cycle, because reset is asynchronous. After release, restart at SNAP.
- Never more than one an bit is low at a time.

Test Plan:
- All scenarios use SCAN_DIV=4, BLANK_CYCLES=1, so the frame period is 41 cycles.
- Reset: hold res=1 for 5 cycles -> an=FF, seg=7F, dp=1, frame=0. Release -> frame=1 for one cycle, then an=7F for 4 cycles; frame recurs every 41 cycles.
- Normal display: hora=13, minutos=45, segundos=27, centsegundos=8, nrc=0, blank_lead=0 -> per idx 7..0:
  - seg = 79, 30, 19, 12, 24, 78, 40, 00.
  - dp=0 only on idx 6, 4, 2.
  - Each digit is lit 4 cycles, with a 1-cycle all-off gap between digits.
- Tear-free: change segundos 27->28 while idx=5 is lit -> idx 3/2 still show 24/78 this frame; 24/00 appear after the next frame pulse.
- Invalid field: segundos=60, others as in the normal-display scenario -> idx 3 and 2 show seg=3F with dp=0 on idx 2; the other digits are unchanged.
- Blank lead and mode: hora=5, blank_lead=1, nrc=1 -> idx 7 has an=7F with seg=7F; idx 6 shows seg=12 with dp=0; idx 0 has dp=0.
- Mid-frame reset: assert res during SHOW of idx 4 -> an=FF in the same cycle. On release, frame pulses and the scan restarts at idx 7.

Source files
------------

// File: rtl/time_display_scan.sv
// Eight-digit seven-segment scanner for the HH.MM.SS.cc time bus. The time bus
// is captured once per frame so a carry mid-scan cannot tear the display.
module time_display_scan #(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned BLANK_CYCLES = 2
) (
   input  logic       clk,
   input  logic       res,
   input  logic [6:0] centsegundos,
   input  logic [5:0] segundos,
   input  logic [5:0] minutos,
   input  logic [4:0] hora,
   input  logic       nrc,
   input  logic       blank_lead,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame
);

   localparam int unsigned MAXC = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
   localparam int unsigned CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {SNAP, SHOW, GAP} state_t;

   state_t        state_q;
   logic [2:0]    idx_q;
   logic [CW-1:0] cnt_q;
   logic [6:0]    snap_cs_q;
   logic [5:0]    snap_s_q, snap_m_q;
   logic [4:0]    snap_h_q;
   logic          snap_nrc_q, snap_bl_q;
   logic [7:0]    an_q;
   logic [6:0]    seg_q;
   logic          dp_q, frame_q;

   logic [6:0]    fval;
   logic          fok;
   logic [3:0]    digit;
   logic [6:0]    seg_d;
   logic          dp_d;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0: seg_code = 7'h40;
         4'd1: seg_code = 7'h79;
         4'd2: seg_code = 7'h24;
         4'd3: seg_code = 7'h30;
         4'd4: seg_code = 7'h19;
         4'd5: seg_code = 7'h12;
         4'd6: seg_code = 7'h02;
         4'd7: seg_code = 7'h78;
         4'd8: seg_code = 7'h00;
         4'd9: seg_code = 7'h10;
         default: seg_code = 7'h7F;
      endcase
   endfunction

   // Digit pairs: idx[2:1] picks the field, idx[0]=1 is the tens digit.
   always_comb begin
      fval = '0;
      fok  = 1'b1;
      case (idx_q[2:1])
         2'd3: begin fval = {2'b00, snap_h_q}; fok = (snap_h_q <= 5'd23);  end
         2'd2: begin fval = {1'b0, snap_m_q};  fok = (snap_m_q <= 6'd59);  end
         2'd1: begin fval = {1'b0, snap_s_q};  fok = (snap_s_q <= 6'd59);  end
         default: begin fval = snap_cs_q;      fok = (snap_cs_q <= 7'd99); end
      endcase
      digit = idx_q[0] ? 4'(fval / 7'd10) : 4'(fval % 7'd10);
      if (!fok)
         seg_d = 7'h3F;
      else if (idx_q == 3'd7 && snap_bl_q && snap_h_q < 5'd10)
         seg_d = 7'h7F;
      else
         seg_d = seg_code(digit);
      dp_d = !((idx_q == 3'd6) || (idx_q == 3'd4) || (idx_q == 3'd2) ||
               (idx_q == 3'd0 && snap_nrc_q));
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q    <= SNAP;
         idx_q      <= 3'd7;
         cnt_q      <= '0;
         snap_cs_q  <= '0;
         snap_s_q   <= '0;
         snap_m_q   <= '0;
         snap_h_q   <= '0;
         snap_nrc_q <= 1'b0;
         snap_bl_q  <= 1'b0;
         an_q       <= 8'hFF;
         seg_q      <= 7'h7F;
         dp_q       <= 1'b1;
         frame_q    <= 1'b0;
      end else begin
         an_q    <= 8'hFF;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         frame_q <= 1'b0;
         case (state_q)
            SNAP: begin
               snap_cs_q  <= centsegundos;
               snap_s_q   <= segundos;
               snap_m_q   <= minutos;
               snap_h_q   <= hora;
               snap_nrc_q <= nrc;
               snap_bl_q  <= blank_lead;
               frame_q    <= 1'b1;
               idx_q      <= 3'd7;
               cnt_q      <= '0;
               state_q    <= SHOW;
            end
            SHOW: begin
               an_q  <= ~(8'b1 << idx_q);
               seg_q <= seg_d;
               dp_q  <= dp_d;
               if (cnt_q == CW'(SCAN_DIV - 1)) begin
                  cnt_q <= '0;
                  if (BLANK_CYCLES > 0)
                     state_q <= GAP;
                  else if (idx_q == 3'd0)
                     state_q <= SNAP;
                  else
                     idx_q <= idx_q - 3'd1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            GAP: begin
               if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                  cnt_q <= '0;
                  if (idx_q == 3'd0) begin
                     state_q <= SNAP;
                  end else begin
                     idx_q   <= idx_q - 3'd1;
                     state_q <= SHOW;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= SNAP;
         endcase
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign dp    = dp_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Bench for time_display_scan: a frame-position reference model predicts every
// output cycle from the snapshot captured at each frame pulse.
module tb_time_display_scan;

   localparam int SD = 4;
   localparam int BC = 1;
   localparam int FP = 1 + 8 * (SD + BC);

   typedef struct packed {
      logic [6:0] cs;
      logic [5:0] s;
      logic [5:0] m;
      logic [4:0] h;
      logic       nrc;
      logic       bl;
   } tv_t;

   logic       clk = 1'b0;
   logic       res = 1'b1;
   logic [6:0] centsegundos = '0;
   logic [5:0] segundos = '0;
   logic [5:0] minutos = '0;
   logic [4:0] hora = '0;
   logic       nrc = 1'b0;
   logic       blank_lead = 1'b0;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame;

   int n_cmp = 0;
   int n_err = 0;

   logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   time_display_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
      .clk(clk), .res(res), .centsegundos(centsegundos), .segundos(segundos),
      .minutos(minutos), .hora(hora), .nrc(nrc), .blank_lead(blank_lead),
      .an(an), .seg(seg), .dp(dp), .frame(frame)
   );

   always #5 clk = ~clk;

   // Expected {an,seg,dp,frame} at position p of a frame (p=0 is the pulse).
   function automatic logic [16:0] model(input int p, input tv_t t);
      logic [7:0] e_an = 8'hFF;
      logic [6:0] e_seg = 7'h7F;
      logic       e_dp = 1'b1;
      logic       e_fr = 1'b0;
      int q, d, v, lim;
      if (p == 0) begin
         e_fr = 1'b1;
      end else begin
         q = p - 1;
         d = 7 - q / (SD + BC);
         if (q % (SD + BC) < SD) begin
            e_an = 8'hFF;
            e_an[d] = 1'b0;
            case (d / 2)
               3: begin v = int'(t.h);  lim = 23; end
               2: begin v = int'(t.m);  lim = 59; end
               1: begin v = int'(t.s);  lim = 59; end
               default: begin v = int'(t.cs); lim = 99; end
            endcase
            if (v > lim) e_seg = 7'h3F;
            else if (d == 7 && t.bl && v < 10) e_seg = 7'h7F;
            else e_seg = segtab[(d % 2 == 1) ? v / 10 : v % 10];
            e_dp = !(d == 6 || d == 4 || d == 2 || (d == 0 && t.nrc));
         end
      end
      return {e_an, e_seg, e_dp, e_fr};
   endfunction

   task automatic drive(input tv_t t);
      centsegundos = t.cs; segundos = t.s; minutos = t.m;
      hora = t.h; nrc = t.nrc; blank_lead = t.bl;
   endtask

   function automatic tv_t rand_tv();
      tv_t t;
      t.cs = 7'($urandom_range(0, 110));
      t.s  = 6'($urandom_range(0, 63));
      t.m  = 6'($urandom_range(0, 63));
      t.h  = 5'($urandom_range(0, 31));
      t.nrc = 1'($urandom_range(0, 1));
      t.bl  = 1'($urandom_range(0, 1));
      return t;
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({an, seg, dp, frame} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset cyc=%0d got=%h/%h/%b/%b want=ff/7f/1/0", i, an, seg, dp, frame);
         end
      end
      res = 1'b0;
   endtask

   task automatic test_normal();
      tv_t t = '{cs: 7'd8, s: 6'd27, m: 6'd45, h: 5'd13, nrc: 1'b0, bl: 1'b0};
      logic [6:0] want [8] = '{7'h00, 7'h40, 7'h78, 7'h24, 7'h12, 7'h19, 7'h30, 7'h79};
      logic [16:0] got, exp;
      drive(t);
      @(negedge clk);
      n_cmp++;
      if (frame !== 1'b1) begin
         n_err++;
         $display("FAIL normal_pulse got frame=%b want 1", frame);
      end
      for (int p = 1; p < FP; p++) begin
         @(negedge clk);
         got = {an, seg, dp, frame};
         exp = model(p, t);
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL normal p=%0d got=%h want=%h", p, got, exp);
         end
         if ((p - 1) % (SD + BC) == 0) begin
            n_cmp++;
            if (seg !== want[7 - (p - 1) / (SD + BC)]) begin
               n_err++;
               $display("FAIL normal_digit p=%0d got seg=%h want %h", p, seg,
                        want[7 - (p - 1) / (SD + BC)]);
            end
         end
      end
   endtask

   task automatic test_tearfree();
      tv_t t = '{cs: 7'd8, s: 6'd27, m: 6'd45, h: 5'd13, nrc: 1'b0, bl: 1'b0};
      tv_t t2;
      logic [16:0] got, exp;
      t2 = t; t2.s = 6'd28;
      drive(t);
      for (int f = 0; f < 2; f++) begin
         for (int p = 0; p < FP; p++) begin
            @(negedge clk);
            got = {an, seg, dp, frame};
            exp = model(p, (f == 0) ? t : t2);
            n_cmp++;
            if (got !== exp) begin
               n_err++;
               $display("FAIL tearfree f=%0d p=%0d got=%h want=%h", f, p, got, exp);
            end
            if (f == 0 && p == 12) drive(t2);
            if (p == 26) begin
               n_cmp++;
               if (seg !== ((f == 0) ? 7'h78 : 7'h00)) begin
                  n_err++;
                  $display("FAIL tearfree_units f=%0d got seg=%h", f, seg);
               end
            end
         end
      end
   endtask

   task automatic test_invalid();
      tv_t t = '{cs: 7'd8, s: 6'd60, m: 6'd45, h: 5'd13, nrc: 1'b0, bl: 1'b0};
      logic [16:0] got, exp;
      drive(t);
      for (int p = 0; p < FP; p++) begin
         @(negedge clk);
         got = {an, seg, dp, frame};
         exp = model(p, t);
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL invalid p=%0d got=%h want=%h", p, got, exp);
         end
         if (p == 21 || p == 26) begin
            n_cmp++;
            if (seg !== 7'h3F || dp !== (p == 21)) begin
               n_err++;
               $display("FAIL invalid_dash p=%0d got seg=%h dp=%b", p, seg, dp);
            end
         end
      end
   endtask

   task automatic test_blank_lead();
      tv_t t = '{cs: 7'd42, s: 6'd9, m: 6'd3, h: 5'd5, nrc: 1'b1, bl: 1'b1};
      logic [16:0] got, exp;
      drive(t);
      for (int p = 0; p < FP; p++) begin
         @(negedge clk);
         got = {an, seg, dp, frame};
         exp = model(p, t);
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL blank p=%0d got=%h want=%h", p, got, exp);
         end
         if (p == 1 && {an, seg} !== {8'h7F, 7'h7F}) begin
            n_err++;
            $display("FAIL blank_lead got an=%h seg=%h want 7f/7f", an, seg);
         end
         if (p == 6 && {seg, dp} !== {7'h12, 1'b0}) begin
            n_err++;
            $display("FAIL blank_units got seg=%h dp=%b want 12/0", seg, dp);
         end
         if (p == 36 && dp !== 1'b0) begin
            n_err++;
            $display("FAIL blank_nrc_dp got dp=%b want 0", dp);
         end
      end
      n_cmp += 3;
   endtask

   task automatic test_random();
      tv_t snap, cur;
      int chg;
      logic [16:0] got, exp;
      cur = rand_tv();
      drive(cur);
      for (int f = 0; f < 8; f++) begin
         snap = cur;
         chg = $urandom_range(1, FP - 2);
         for (int p = 0; p < FP; p++) begin
            @(negedge clk);
            got = {an, seg, dp, frame};
            exp = model(p, snap);
            n_cmp++;
            if (got !== exp || !$onehot0(~an)) begin
               n_err++;
               $display("FAIL random f=%0d p=%0d got=%h want=%h", f, p, got, exp);
            end
            if (p == chg || p == FP - 1) begin
               cur = rand_tv();
               drive(cur);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      tv_t t = '{cs: 7'd99, s: 6'd59, m: 6'd59, h: 5'd23, nrc: 1'b1, bl: 1'b0};
      logic [16:0] got, exp;
      drive(t);
      for (int p = 0; p < 18; p++) begin
         @(negedge clk);
         got = {an, seg, dp, frame};
         exp = model(p, t);
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL midrst_pre p=%0d got=%h want=%h", p, got, exp);
         end
      end
      res = 1'b1;
      #1;
      n_cmp++;
      if ({an, seg, dp, frame} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL midrst_async got=%h/%h/%b/%b want=ff/7f/1/0", an, seg, dp, frame);
      end
      @(negedge clk);
      @(negedge clk);
      res = 1'b0;
      for (int p = 0; p < FP; p++) begin
         @(negedge clk);
         got = {an, seg, dp, frame};
         exp = model(p, t);
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL midrst_post p=%0d got=%h want=%h", p, got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_tearfree();
      test_invalid();
      test_blank_lead();
      test_random();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
